pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS-32 pipeline. It takes the load-use hazard flag from hazard detection, the taken-branch redirect from EX, and the data-memory request/ready handshake from MEM. From these it drives every pipeline-register write enable and flush. It also provides saturating performance counters and a sticky memory-timeout flag.

## Interface
- `CNT_W`, 16: width of `stall_count` and `flush_count`.
- `MAX_WAIT`, 15: MEM_WAIT cycles tolerated before timeout; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `load_use_hazard`  in  1  ID instruction depends on a load in EX.
- `branch_taken`  in  1  EX resolved a taken branch/jump; PC mux already selects target.
- `dmem_req`  in  1  MEM stage holds a load/store this cycle.
- `dmem_ready`  in  1  data memory completes the MEM access this cycle.
- `pc_write`  out  1  PC update enable.
- `if_id_write`  out  1  IF/ID register enable.
- `id_ex_write`  out  1  ID/EX register enable.
- `ex_mem_write`  out  1  EX/MEM register enable.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_ex_flush`  out  1  load NOP (all control zero) into ID/EX.
- `mem_wb_bubble`  out  1  load NOP into MEM/WB.
- `stall_count`  out  CNT_W  cycles with `pc_write`=0 in RUN/MEM_WAIT; saturating.
- `flush_count`  out  CNT_W  accepted branch flushes; saturating.
- `mem_timeout`  out  1  sticky; set on wait overrun.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state RUN.
- Outputs are Mealy (state + current inputs); counters, wait counter and `mem_timeout` are registered.
- Default in RUN (no event): all `*_write`=1, all flush/bubble=0.
- RUN priority, highest first:
  - `dmem_req`&&!`dmem_ready`: pc/if_id/id_ex/ex_mem writes=0, `mem_wb_bubble`=1. Next state MEM_WAIT, wait counter := 1.
  - `branch_taken`: `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1. `flush_count`++.
  - `load_use_hazard`: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. Exactly one bubble per hazard, because the hazard clears once the load leaves EX.
- A taken branch always supersedes load-use. The ID instruction is discarded, so no stall is counted.
- MEM_WAIT:
  - While `dmem_ready`=0: full freeze plus `mem_wb_bubble`=1, and the wait counter increments.
  - `dmem_ready`=1: the RUN rules apply to the other inputs in the same cycle, without the mem-wait term; next state RUN.
  - `branch_taken`/`load_use_hazard` stay asserted because EX/ID are frozen. They are acted on only in the ready cycle.
- Timeout: `dmem_ready` still 0 in a cycle where the wait counter equals `MAX_WAIT`. Then `mem_timeout`:=1 and next state HALT.
- HALT: full freeze, `mem_wb_bubble`=1, inputs ignored. Exit only via reset.
- Counters saturate at 2^CNT_W−1 and never wrap. HALT cycles are not counted.

## Timing
- Zero-cycle latency: enables and flushes respond combinationally in the same cycle as their inputs.
- While `reset_n`=0:
  - All `*_write`=0.
  - `if_id_flush`=`id_ex_flush`=`mem_wb_bubble`=1.
  - `stall_count`=`flush_count`=0, `mem_timeout`=0, state RUN.
- The first edge after `reset_n` rises operates in RUN.
- Reset mid-MEM_WAIT or in HALT: immediate return to the reset values above, without waiting for a clock.
- Memory handshake: a single-cycle `dmem_req`&&`dmem_ready` costs 0 stall cycles. N cycles with ready low cost N stall cycles.
- `dmem_req` low while in MEM_WAIT is a protocol violation. The FSM treats it as `dmem_ready`=1.

## Structure
- Shared package `mips_pipe_pkg`:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2).
  - Default `CNT_W` and `MAX_WAIT` constants.
- One sub-module, `sat_counter` (parameter width; clear/increment inputs; async active-low reset). It is instantiated for `stall_count`, `flush_count` and the wait counter.

## Test plan
- Reset, then idle in RUN for 3 cycles → all writes 1, no flushes, `stall_count`=0.
- `load_use_hazard` high for 1 cycle → `pc_write`=`if_id_write`=0, `id_ex_flush`=1; `stall_count`=1.
- `branch_taken` and `load_use_hazard` high together → flushes 1, `pc_write`=1, `flush_count`=1, `stall_count` unchanged.
- `dmem_req`=1 with `dmem_ready` low for 4 cycles, then high, with `branch_taken` held → 4 frozen cycles with `mem_wb_bubble`=1. Flush fires in the ready cycle; `stall_count`=4, `flush_count`=1.
- `MAX_WAIT`=3, `dmem_ready` never rises → `mem_timeout`=1 on the 4th stall cycle. HALT freezes until `reset_n` pulses low, which clears everything.
- `CNT_W`=4 with 20 load-use stalls → `stall_count` saturates at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS-32 pipeline stall/flush controller.
package mips_pipe_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_WAIT = 15;
  // Wide enough for the largest legal MAX_WAIT (255).
  localparam int WAIT_W       = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Every pipeline-register enable and flush, bundled so a whole pattern moves at once.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 7'b1111_000;  // everything advances
  localparam ctrl_t CTRL_FREEZE = 7'b0000_001;  // hold front end, drain a NOP into MEM/WB
  localparam ctrl_t CTRL_RESET  = 7'b0000_111;  // hold everything, NOPs everywhere

  // Branch/load-use handling once the memory stage is not holding the pipe.
  // A taken branch discards the ID instruction, so it wins over load-use.
  function automatic ctrl_t apply_events(input logic branch_taken,
                                         input logic load_use_hazard);
    ctrl_t c;
    c = CTRL_RUN;
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use_hazard) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs, memory handshake and pipeline control outputs of the stall controller.
interface pipeline_stall_controller_if
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             load_use_hazard;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  // Pipeline side: raises hazards/requests, consumes enables.
  modport master (
    output load_use_hazard, branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble,
           stall_count, flush_count, mem_timeout
  );

  // Controller side.
  modport slave (
    input  load_use_hazard, branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_wb_bubble,
           stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter. clear forces zero; clear together with inc loads one.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: clear/load-one has priority, then saturating increment.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS-32 pipeline: Mealy control of
// all pipeline-register enables/flushes, saturating perf counters, sticky mem timeout.
module pipeline_stall_controller
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pipeline_stall_controller_if.slave  bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = MAX_WAIT[WAIT_W-1:0];

  state_t            state;
  state_t            state_next;
  ctrl_t             ctrl;
  ctrl_t             ctrl_out;
  logic              stall_inc;
  logic              flush_inc;
  logic              wait_clr;
  logic              wait_inc;
  logic              timeout_set;
  logic              mem_timeout_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // Next state, control pattern and counter strobes from state plus live inputs.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_next  = state;
    ctrl        = CTRL_RUN;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          ctrl       = CTRL_FREEZE;
          state_next = MEM_WAIT;
          wait_clr   = 1'b1;     // with wait_inc, loads the wait counter with 1
          wait_inc   = 1'b1;
        end else begin
          ctrl = apply_events(bus.branch_taken, bus.load_use_hazard);
        end
      end
      MEM_WAIT: begin
        // A dropped request mid-wait is treated as completion.
        if (bus.dmem_req && !bus.dmem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == MAX_WAIT_C) begin
            timeout_set = 1'b1;
            state_next  = HALT;
          end else begin
            wait_inc = 1'b1;
          end
        end else begin
          ctrl       = apply_events(bus.branch_taken, bus.load_use_hazard);
          state_next = RUN;
        end
      end
      HALT: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        ctrl       = CTRL_FREEZE;
        state_next = RUN;
      end
    endcase
    // Freeze and HALT patterns never flush IF/ID, so this counts accepted branches only.
    flush_inc = ctrl.if_id_flush;
    stall_inc = (state != HALT) && !ctrl.pc_write;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         mem_timeout_q <= 1'b0;
    else if (timeout_set) mem_timeout_q <= 1'b1;
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clear (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  // Reset overrides the control pattern combinationally, without waiting for a clock.
  assign ctrl_out = reset_n ? ctrl : CTRL_RESET;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.if_id_write   = ctrl_out.if_id_write;
  assign bus.id_ex_write   = ctrl_out.id_ex_write;
  assign bus.ex_mem_write  = ctrl_out.ex_mem_write;
  assign bus.if_id_flush   = ctrl_out.if_id_flush;
  assign bus.id_ex_flush   = ctrl_out.id_ex_flush;
  assign bus.mem_wb_bubble = ctrl_out.mem_wb_bubble;
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;
  assign bus.mem_timeout   = mem_timeout_q;

endmodule
